// File: rtl/accel_ram_ctrl.sv
// Accelerometer sample RAM controller: circular history logging, read arbitration, full-depth clear.
// Optional peak tracking enabled by defining ACCEL_PEAK_TRACK_EN.
module accel_ram_ctrl #(
  parameter int NBits = 7,
  parameter int NAddr = 3
) (
  input  logic             clk,
  input  logic             rst_a,
  input  logic             clear_req,
  input  logic             sample_valid,
  input  logic [NBits-1:0] sample_data,
  output logic             sample_ready,
  input  logic             rd_req,
  input  logic [NAddr-1:0] rd_index,
  output logic             rd_ack,
  output logic             rd_valid,
  output logic [NBits-1:0] rd_data,
  output logic             rd_err,
  output logic [NAddr:0]   count,
  output logic             busy,
  output logic [NBits-1:0] peak,
  output logic             ram_wr_en,
  output logic [NAddr-1:0] ram_addr,
  output logic [NBits-1:0] ram_data_in,
  input  logic [NBits-1:0] ram_data_out
);

  localparam logic [NAddr:0] FULL = {1'b1, {NAddr{1'b0}}};

  typedef enum logic [2:0] {CLEAR, IDLE, WRITE, RD_ADDR, RD_DATA} state_t;

  state_t           state, state_nxt;
  logic [NAddr-1:0] clr_ptr, wr_ptr, rd_addr;
  logic [NBits-1:0] wr_buf;
  logic             rd_err_q, clr_pend, clr_go, clr_last;

  // A latched clear outranks everything on return to IDLE, so nothing is accepted meanwhile
  assign clr_go   = clear_req | clr_pend;
  assign clr_last = (state == CLEAR) && (clr_ptr == '1);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_a)
    if (!rst_a) state <= CLEAR;
    else        state <= state_nxt;

  always_comb begin
    state_nxt    = state;
    sample_ready = 1'b0;
    rd_ack       = 1'b0;
    ram_wr_en    = 1'b1;
    ram_addr     = '0;
    ram_data_in  = '0;
    case (state)
      CLEAR: begin
        ram_wr_en = 1'b0;
        ram_addr  = clr_ptr;
        if (clr_ptr == '1) state_nxt = IDLE;
      end
      IDLE: begin
        sample_ready = !clr_go;
        rd_ack       = rd_req && !sample_valid && !clr_go;
        if (clr_go)            state_nxt = CLEAR;
        else if (sample_valid) state_nxt = WRITE;
        else if (rd_req)       state_nxt = RD_ADDR;
      end
      WRITE: begin
        ram_wr_en   = 1'b0;
        ram_addr    = wr_ptr;
        ram_data_in = wr_buf;
        state_nxt   = IDLE;
      end
      RD_ADDR: begin
        ram_addr  = rd_addr;
        state_nxt = RD_DATA;
      end
      RD_DATA: state_nxt = IDLE;
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      clr_ptr  <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      wr_buf   <= '0;
      rd_addr  <= '0;
      rd_err_q <= 1'b0;
      clr_pend <= 1'b0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (clear_req && state != IDLE) clr_pend <= 1'b1;
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_last) begin
            wr_ptr <= '0;
            count  <= '0;
          end
        end
        IDLE: begin
          if (clr_go) begin
            clr_ptr  <= '0;
            clr_pend <= 1'b0;
          end else if (sample_valid) begin
            wr_buf <= sample_data;
          end else if (rd_req) begin
            // wr_ptr - 1 - rd_index == wr_ptr + ~rd_index (mod DEPTH)
            rd_addr  <= wr_ptr + ~rd_index;
            rd_err_q <= ({1'b0, rd_index} >= count);
          end
        end
        WRITE: begin
          wr_ptr <= wr_ptr + 1'b1;
          if (count != FULL) count <= count + 1'b1;
        end
        RD_DATA: begin
          rd_valid <= 1'b1;
          rd_err   <= rd_err_q;
          rd_data  <= rd_err_q ? '0 : ram_data_out;
        end
        default: ;
      endcase
    end
  end

`ifdef ACCEL_PEAK_TRACK_EN
  logic [NBits-1:0] peak_q;

  always_ff @(posedge clk or negedge rst_a)
    if (!rst_a)                                 peak_q <= '0;
    else if (clr_last)                          peak_q <= '0;
    else if (state == WRITE && wr_buf > peak_q) peak_q <= wr_buf;

  assign peak = peak_q;
`else
  assign peak = '0;
`endif

endmodule
